// File: rtl/alu_seq.sv
// Handshaked integer ALU: single-cycle base ops and optional iterative mul/div.
// Define ALU_MULDIV_EN to build the mul/div opcodes (16-19) and their BUSY datapath.
module alu_seq #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [4:0]      func_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] res_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd2;
`ifdef ALU_MULDIV_EN
  localparam logic [1:0] ST_BUSY = 2'd1;
`endif

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_LT   = 5'd3;
  localparam logic [4:0] OP_LTU  = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_EQ   = 5'd10;
  localparam logic [4:0] OP_NE   = 5'd11;
  localparam logic [4:0] OP_GE   = 5'd12;
  localparam logic [4:0] OP_GEU  = 5'd13;

  // Single-cycle result; anything not listed (including 16-19 without mul/div) yields zero.
  function automatic logic [XLEN-1:0] alu_op(input logic [4:0] f,
                                             input logic [XLEN-1:0] x,
                                             input logic [XLEN-1:0] y);
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] r;
    sh = y[SHW-1:0];
    case (f)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_SLL:  r = x << sh;
      OP_LT:   r = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_LTU:  r = {{(XLEN-1){1'b0}}, (x < y)};
      OP_XOR:  r = x ^ y;
      OP_SRL:  r = x >> sh;
      OP_SRA:  r = $unsigned($signed(x) >>> sh);
      OP_OR:   r = x | y;
      OP_AND:  r = x & y;
      OP_EQ:   r = {{(XLEN-1){1'b0}}, (x == y)};
      OP_NE:   r = {{(XLEN-1){1'b0}}, (x != y)};
      OP_GE:   r = {{(XLEN-1){1'b0}}, ($signed(x) >= $signed(y))};
      OP_GEU:  r = {{(XLEN-1){1'b0}}, (x >= y)};
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            out_valid_q, out_valid_d;
  logic            accept_s;

`ifdef ALU_MULDIV_EN
  // hi/lo hold {accumulator, multiplier} for mul and {remainder, quotient} for div.
  logic [SHW:0]    cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic            div_q, div_d, sel_hi_q, sel_hi_d;
  logic            is_muldiv_s;
  logic [XLEN:0]   mul_sum_s;
  logic [XLEN:0]   rem_shift_s;
  logic [XLEN-1:0] rem_sub_s;
  logic            rem_ge_s;

  assign in_ready_o  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready_i);
  assign is_muldiv_s = (func_i[4:2] == 3'b100);
  assign mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign rem_shift_s = {hi_q, lo_q[XLEN-1]};
  assign rem_ge_s    = (rem_shift_s >= {1'b0, opb_q});
  assign rem_sub_s   = rem_shift_s[XLEN-1:0] - opb_q;
`else
  assign in_ready_o  = (state_q == ST_IDLE) || out_ready_i;
`endif

  assign accept_s    = in_valid_i && in_ready_o;
  assign out_valid_o = out_valid_q;
  assign res_o       = res_q;

  // Next-state, result and iterative datapath control.
  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
`ifdef ALU_MULDIV_EN
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    div_d    = div_q;
    sel_hi_d = sel_hi_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
`ifdef ALU_MULDIV_EN
          if (is_muldiv_s) begin
            state_d     = ST_BUSY;
            out_valid_d = 1'b0;
            cnt_d       = (SHW+1)'(XLEN);
            hi_d        = {XLEN{1'b0}};
            lo_d        = a_i;
            opb_d       = b_i;
            div_d       = func_i[1];
            sel_hi_d    = func_i[0];
          end else begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            res_d       = alu_op(func_i, a_i, b_i);
          end
`else
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          res_d       = alu_op(func_i, a_i, b_i);
`endif
        end else if ((state_q == ST_DONE) && out_ready_i) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
`ifdef ALU_MULDIV_EN
      ST_BUSY: begin
        if (cnt_q == {(SHW+1){1'b0}}) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          res_d       = sel_hi_q ? hi_q : lo_q;
        end else begin
          cnt_d = cnt_q - {{SHW{1'b0}}, 1'b1};
          if (div_q) begin
            if (rem_ge_s) begin
              hi_d = rem_sub_s;
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = rem_shift_s[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = mul_sum_s[XLEN:1];
            lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
          end
        end
      end
`endif
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      res_q       <= {XLEN{1'b0}};
      out_valid_q <= 1'b0;
`ifdef ALU_MULDIV_EN
      cnt_q    <= {(SHW+1){1'b0}};
      hi_q     <= {XLEN{1'b0}};
      lo_q     <= {XLEN{1'b0}};
      opb_q    <= {XLEN{1'b0}};
      div_q    <= 1'b0;
      sel_hi_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_MULDIV_EN
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      div_q    <= div_d;
      sel_hi_q <= sel_hi_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (XLEN=32); mul/div checks follow ALU_MULDIV_EN.
module tb_alu_seq;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  func;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;

  int tests = 0;
  int fails = 0;

  alu_seq #(.XLEN(32)) dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .func_i     (func),
    .a_i        (a),
    .b_i        (b),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .res_o      (res)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Offer one single-cycle op with out_ready=1; result must appear one edge later.
  task automatic run_single(input string tag, input logic [4:0] f,
                            input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] exp);
    out_ready = 1'b1;
    func = f; a = x; b = y; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; func = 5'd1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check(tag, res, exp);
    @(negedge clock);
  endtask

`ifdef ALU_MULDIV_EN
  // Offer one iterative op; out_valid must rise exactly 33 edges after acceptance.
  task automatic run_muldiv(input string tag, input logic [4:0] f,
                            input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] exp);
    logic early_s;
    logic ready_s;
    out_ready = 1'b1;
    func = f; a = x; b = y; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    a = 32'h0; b = 32'h0; func = 5'd0;
    early_s = 1'b0;
    ready_s = 1'b0;
    for (int i = 0; i < 32; i++) begin
      early_s = early_s | out_valid;
      ready_s = ready_s | in_ready;
      @(negedge clock);
    end
    check({tag, "_early"}, {31'd0, early_s}, 32'd0);
    check({tag, "_busy_ready"}, {31'd0, ready_s}, 32'd0);
    @(negedge clock);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check(tag, res, exp);
    @(negedge clock);
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    func = 5'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    @(negedge clock);

`ifdef ALU_MULDIV_EN
    func = 5'd18; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check("busy_ready", {31'd0, in_ready}, 32'd0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
`else
    func = 5'd0; a = 32'd5; b = 32'd6; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check("pre_rst_res", res, 32'd11);
    reset = 1'b1;
`endif
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_res", res, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    run_single("add_3_4", 5'd0, 32'd3, 32'd4, 32'd7);
    check("idle_after_take", {31'd0, out_valid}, 32'd0);

    // Back-to-back stream with out_ready held high.
    out_ready = 1'b1;
    func = 5'd1; a = 32'd5; b = 32'd7; in_valid = 1'b1;
    @(negedge clock);
    check("b2b_sub", res, 32'hFFFF_FFFE);
    check("b2b_ready", {31'd0, in_ready}, 32'd1);
    func = 5'd7; a = 32'h8000_0000; b = 32'd4;
    @(negedge clock);
    check("b2b_sra", res, 32'hF800_0000);
    func = 5'd3; a = 32'hFFFF_FFFF; b = 32'd1;
    @(negedge clock);
    check("b2b_lt", res, 32'd1);
    check("b2b_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    @(negedge clock);
    check("b2b_drain", {31'd0, out_valid}, 32'd0);

    run_single("sll_wrap", 5'd2, 32'd1, 32'd33, 32'd2);
    run_single("srl", 5'd6, 32'h8000_0000, 32'd4, 32'h0800_0000);
    run_single("ltu", 5'd4, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_single("xor", 5'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB);
    run_single("or", 5'd8, 32'h0000_F00F, 32'h1200_0FF0, 32'h1200_FFFF);
    run_single("and", 5'd9, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00);
    run_single("eq", 5'd10, 32'd5, 32'd5, 32'd1);
    run_single("ne", 5'd11, 32'd5, 32'd5, 32'd0);
    run_single("ge", 5'd12, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_single("geu", 5'd13, 32'hFFFF_FFFF, 32'd1, 32'd1);
    run_single("add_wrap", 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_single("undef14", 5'd14, 32'd3, 32'd4, 32'd0);
    run_single("undef31", 5'd31, 32'd3, 32'd4, 32'd0);

    // Back-pressure: result must hold and a waiting op must not be taken.
    out_ready = 1'b0;
    func = 5'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    @(negedge clock);
    func = 5'd0; a = 32'd9; b = 32'd9;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_res", res, 32'd2);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
    check("bp_next_res", res, 32'd18);
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clock);
    check("bp_drain", {31'd0, out_valid}, 32'd0);

`ifdef ALU_MULDIV_EN
    run_muldiv("mul", 5'd16, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    run_muldiv("mulhu", 5'd17, 32'hFFFF_FFFF, 32'd2, 32'd1);
    run_muldiv("divu", 5'd18, 32'd100, 32'd7, 32'd14);
    run_muldiv("remu", 5'd19, 32'd100, 32'd7, 32'd2);
    run_muldiv("divu_zero", 5'd18, 32'd9, 32'd0, 32'hFFFF_FFFF);
    run_muldiv("remu_zero", 5'd19, 32'd9, 32'd0, 32'd9);
    run_single("add_after_div", 5'd0, 32'd20, 32'd22, 32'd42);
`else
    run_single("func16_undef", 5'd16, 32'd3, 32'd4, 32'd0);
    run_single("func19_undef", 5'd19, 32'd9, 32'd3, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
